// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - composite video sample-count constants and pulse FSM state
//
// Purpose: constants shared between the composite generator and this receiver,
//          all in clk_en samples, plus the state type of the sync pulse FSM.
// Ports:   none (package).
package video_timing_pkg;

    localparam int CLK_DIV       = 16;
    localparam int HSYNC_SAMPLES = 26;
    localparam int BROAD_SAMPLES = 315;
    localparam int LINE_PERIOD   = 341;

    typedef enum logic {
        PS_HIGH = 1'b0,
        PS_LOW  = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/sync_pulse_classifier.sv
// rtl/sync_pulse_classifier.sv - sync/luma synchronizers, pulse FSM and width classification
//
// Purpose: synchronizes the comparator bits, tracks low pulses on sync_n and
//          classifies each completed pulse by width.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   clk_en           sample enable
//   sync_n, luma     asynchronous comparator outputs
//   luma_s           synchronized luma
//   lead_edge        sample enable cycle that sees a pulse start
//   hsync_evt        sample enable cycle that ends a valid hsync
//   vsync_evt        sample enable cycle that ends a broad pulse
//   invalid_evt      sample enable cycle that ends a pulse between hsync and broad widths
//   in_sync          FSM is inside a low pulse
module sync_pulse_classifier
    import video_timing_pkg::*;
#(
    parameter int HSYNC_MIN = 16,
    parameter int HSYNC_MAX = 40,
    parameter int VSYNC_MIN = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic sync_n,
    input  logic luma,
    output logic luma_s,
    output logic lead_edge,
    output logic hsync_evt,
    output logic vsync_evt,
    output logic invalid_evt,
    output logic in_sync
);

    localparam logic [8:0] W_HMIN = 9'(HSYNC_MIN);
    localparam logic [8:0] W_HMAX = 9'(HSYNC_MAX);
    localparam logic [8:0] W_VMIN = 9'(VSYNC_MIN);

    logic [1:0]   sync_ff;
    logic [1:0]   luma_ff;
    logic         sync_s;
    logic         sync_prev;
    pulse_state_t state;
    logic [8:0]   width;
    logic [8:0]   width_inc;
    logic         rise;

    assign sync_s    = sync_ff[1];
    assign luma_s    = luma_ff[1];
    assign width_inc = (width == 9'h1FF) ? width : width + 9'd1;

    // A pulse starts only on a real 1->0 transition of the sampled bit, so a
    // reset taken while sync is low leaves the tail of that pulse unclassified.
    assign lead_edge   = clk_en && (state == PS_HIGH) && !sync_s && sync_prev;
    assign rise        = clk_en && (state == PS_LOW) && sync_s;

    // width_inc on the rising sample equals the number of low samples seen.
    assign hsync_evt   = rise && (width_inc >= W_HMIN) && (width_inc <= W_HMAX);
    assign vsync_evt   = rise && (width_inc >= W_VMIN);
    assign invalid_evt = rise && (width_inc > W_HMAX) && (width_inc < W_VMIN);
    assign in_sync     = (state == PS_LOW);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff   <= '0;
            luma_ff   <= '0;
            sync_prev <= 1'b0;
            state     <= PS_HIGH;
            width     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], sync_n};
            luma_ff <= {luma_ff[0], luma};
            if (clk_en) begin
                sync_prev <= sync_s;
                if (lead_edge) begin
                    state <= PS_LOW;
                    width <= '0;
                end else if (state == PS_LOW) begin
                    width <= width_inc;
                    if (sync_s) begin
                        state <= PS_HIGH;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/composite_sync_separator.sv
// rtl/composite_sync_separator.sv - composite sync separator with line lock and x/y recovery
//
// Purpose: recovers line/frame timing from sliced composite video.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   clk_en                sample enable (one clk in every 16)
//   sync_n, luma          asynchronous comparator outputs
//   hsync_pulse           one-clk strobe at the trailing edge of a valid hsync
//   vsync_pulse           one-clk strobe at the trailing edge of a broad pulse
//   x                     samples since last sync trailing edge, saturating
//   y                     lines since last vsync, saturating
//   active                inside the locked active window
//   video                 sampled luma
//   locked                line timing locked
module composite_sync_separator
    import video_timing_pkg::*;
#(
    parameter int HSYNC_MIN      = HSYNC_SAMPLES - 10,
    parameter int HSYNC_MAX      = HSYNC_SAMPLES + 14,
    parameter int VSYNC_MIN      = BROAD_SAMPLES - 115,
    parameter int LINE_SAMPLES   = LINE_PERIOD,
    parameter int LINE_TOL       = 8,
    parameter int LOCK_LINES     = 4,
    parameter int ACTIVE_SAMPLES = 300,
    parameter int ACTIVE_LINES   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       sync_n,
    input  logic       luma,
    output logic       hsync_pulse,
    output logic       vsync_pulse,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       active,
    output logic       video,
    output logic       locked
);

    localparam logic [9:0] PER_LO   = 10'(LINE_SAMPLES - LINE_TOL);
    localparam logic [9:0] PER_HI   = 10'(LINE_SAMPLES + LINE_TOL);
    localparam logic [9:0] PER_TMO  = 10'(LINE_SAMPLES + LINE_TOL + 1);
    localparam logic [7:0] GOOD_MAX = 8'(LOCK_LINES);
    localparam logic [9:0] X_ACT    = 10'(ACTIVE_SAMPLES);
    localparam logic [8:0] Y_ACT    = 9'(ACTIVE_LINES);

    logic       luma_s;
    logic       lead_edge;
    logic       hsync_evt;
    logic       vsync_evt;
    logic       invalid_evt;
    logic       in_sync;

    logic [9:0] period;
    logic [9:0] period_inc;
    logic       period_ok;
    logic       timeout_hit;
    logic       timed_out;
    logic       pend_eval;
    logic       pend_good;
    logic       line_good;
    logic       line_bad;
    logic [7:0] good_cnt;
    logic [1:0] bad_cnt;

    sync_pulse_classifier #(
        .HSYNC_MIN (HSYNC_MIN),
        .HSYNC_MAX (HSYNC_MAX),
        .VSYNC_MIN (VSYNC_MIN)
    ) u_classifier (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .sync_n      (sync_n),
        .luma        (luma),
        .luma_s      (luma_s),
        .lead_edge   (lead_edge),
        .hsync_evt   (hsync_evt),
        .vsync_evt   (vsync_evt),
        .invalid_evt (invalid_evt),
        .in_sync     (in_sync)
    );

    // period_inc counts this sample, so a nominal line measures LINE_SAMPLES.
    assign period_inc  = (period == 10'h3FF) ? period : period + 10'd1;
    assign period_ok   = (period_inc >= PER_LO) && (period_inc <= PER_HI);
    // A lead edge on the timeout sample is judged by the edge alone.
    assign timeout_hit = clk_en && !in_sync && !lead_edge && (period_inc == PER_TMO);

    // The period verdict taken at a lead edge is held until the pulse is
    // classified: a glitch discards it (its edge still restarts the period),
    // an invalid-width pulse is bad regardless, and the edge that ends a
    // timed-out line is not judged again.
    assign line_good = (hsync_evt || vsync_evt) && pend_eval && pend_good;
    assign line_bad  = timeout_hit || invalid_evt ||
                       ((hsync_evt || vsync_evt) && pend_eval && !pend_good);

    assign active = locked && !in_sync && (x < X_ACT) && (y < Y_ACT);

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_pulse <= 1'b0;
            vsync_pulse <= 1'b0;
            x           <= '0;
            y           <= '0;
            video       <= 1'b0;
            locked      <= 1'b0;
            period      <= '0;
            timed_out   <= 1'b0;
            pend_eval   <= 1'b0;
            pend_good   <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            hsync_pulse <= hsync_evt;
            vsync_pulse <= vsync_evt;
            if (clk_en) begin
                video <= luma_s;

                if (lead_edge) begin
                    period    <= '0;
                    pend_eval <= !timed_out;
                    pend_good <= period_ok;
                    timed_out <= 1'b0;
                end else begin
                    period <= period_inc;
                    if (timeout_hit) begin
                        timed_out <= 1'b1;
                    end
                end

                if (hsync_evt || vsync_evt) begin
                    x <= '0;
                end else if (x != 10'h3FF) begin
                    x <= x + 10'd1;
                end

                if (vsync_evt) begin
                    y <= '0;
                end else if (hsync_evt && (y != 9'h1FF)) begin
                    y <= y + 9'd1;
                end

                if (line_good) begin
                    bad_cnt <= '0;
                    if (good_cnt != GOOD_MAX) begin
                        good_cnt <= good_cnt + 8'd1;
                    end
                    if (good_cnt + 8'd1 >= GOOD_MAX) begin
                        locked <= 1'b1;
                    end
                end else if (line_bad) begin
                    good_cnt <= '0;
                    if (bad_cnt != 2'd2) begin
                        bad_cnt <= bad_cnt + 2'd1;
                    end
                    if (bad_cnt != 2'd0) begin
                        locked <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_composite_sync_separator.sv
// tb/tb_composite_sync_separator.sv - directed self-checking bench for composite_sync_separator
module tb_composite_sync_separator;
    import video_timing_pkg::*;

    localparam int SAMPLE_CLKS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic       sync_n;
    logic       luma;
    logic       hsync_pulse;
    logic       vsync_pulse;
    logic [9:0] x;
    logic [8:0] y;
    logic       active;
    logic       video;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int vs_cnt = 0;
    int both_cnt = 0;
    int hs0;
    int vs0;

    always #5 clk = ~clk;

    composite_sync_separator dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .sync_n      (sync_n),
        .luma        (luma),
        .hsync_pulse (hsync_pulse),
        .vsync_pulse (vsync_pulse),
        .x           (x),
        .y           (y),
        .active      (active),
        .video       (video),
        .locked      (locked)
    );

    always @(posedge clk) begin
        if (hsync_pulse) hs_cnt <= hs_cnt + 1;
        if (vsync_pulse) vs_cnt <= vs_cnt + 1;
        if (hsync_pulse && vsync_pulse) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic s);
        sync_n = s;
        for (int i = 0; i < SAMPLE_CLKS; i++) begin
            clk_en = (i == SAMPLE_CLKS - 1);
            @(negedge clk);
        end
        clk_en = 1'b0;
    endtask

    task automatic pline(input string tag, input int nl, input int nh,
                         input logic exp_hs, input logic exp_vs, input logic exp_lock);
        repeat (nl) step(1'b0);
        step(1'b1);
        check({tag, " hsync_pulse"}, 32'(hsync_pulse), 32'(exp_hs));
        check({tag, " vsync_pulse"}, 32'(vsync_pulse), 32'(exp_vs));
        check({tag, " locked"}, 32'(locked), 32'(exp_lock));
        if (exp_hs || exp_vs) check({tag, " x"}, 32'(x), 0);
        repeat (nh - 1) step(1'b1);
    endtask

    task automatic glitch_line(input string tag, input logic exp_lock);
        repeat (HSYNC_SAMPLES) step(1'b0);
        step(1'b1);
        check({tag, " hsync_pulse"}, 32'(hsync_pulse), 1);
        check({tag, " locked"}, 32'(locked), 32'(exp_lock));
        repeat (149) step(1'b1);
        repeat (5) step(1'b0);
        repeat (LINE_PERIOD - HSYNC_SAMPLES - 155) step(1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        sync_n = 1'b1;
        luma   = 1'b0;
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst hsync_pulse", 32'(hsync_pulse), 0);
        check("rst vsync_pulse", 32'(vsync_pulse), 0);
        check("rst x", 32'(x), 0);
        check("rst y", 32'(y), 0);
        check("rst active", 32'(active), 0);
        check("rst video", 32'(video), 0);
        check("rst locked", 32'(locked), 0);
        reset = 1'b0;

        // First edge is measured from reset (bad); lines 2..5 are good.
        repeat (3) step(1'b1);
        for (int i = 1; i <= 5; i++) begin
            pline("acq", HSYNC_SAMPLES, LINE_PERIOD - HSYNC_SAMPLES, 1'b1, 1'b0, i == 5);
        end
        check("acq y", 32'(y), 5);

        // Active window edge and luma path on a locked line.
        repeat (HSYNC_SAMPLES) step(1'b0);
        step(1'b1);
        check("win active x0", 32'(active), 1);
        luma = 1'b1;
        step(1'b1);
        check("luma video hi", 32'(video), 1);
        luma = 1'b0;
        step(1'b1);
        check("luma video lo", 32'(video), 0);
        repeat (297) step(1'b1);
        check("win x299", 32'(x), 299);
        check("win active x299", 32'(active), 1);
        step(1'b1);
        check("win active x300", 32'(active), 0);
        repeat (14) step(1'b1);

        // Broad pulse.
        hs0 = hs_cnt;
        vs0 = vs_cnt;
        repeat (2) step(1'b0);
        check("in_sync active", 32'(active), 0);
        repeat (BROAD_SAMPLES - 2) step(1'b0);
        step(1'b1);
        check("vs vsync_pulse", 32'(vsync_pulse), 1);
        check("vs hsync_pulse", 32'(hsync_pulse), 0);
        check("vs y", 32'(y), 0);
        check("vs x", 32'(x), 0);
        repeat (LINE_PERIOD - BROAD_SAMPLES - 1) step(1'b1);
        pline("post_vs", HSYNC_SAMPLES, LINE_PERIOD - HSYNC_SAMPLES, 1'b1, 1'b0, 1'b1);
        check("post_vs y", 32'(y), 1);
        check("vs strobe clks", 32'(vs_cnt - vs0), 1);
        check("vs hs strobes", 32'(hs_cnt - hs0), 1);

        // Glitches: each one makes the following line bad; two in a row unlock.
        hs0 = hs_cnt;
        glitch_line("g1", 1'b1);
        glitch_line("g2", 1'b1);
        pline("g_after", HSYNC_SAMPLES, LINE_PERIOD - HSYNC_SAMPLES, 1'b1, 1'b0, 1'b0);
        check("glitch hs strobes", 32'(hs_cnt - hs0), 3);

        // 60-sample pulse restarts the good-line count.
        pline("l1", HSYNC_SAMPLES, LINE_PERIOD - HSYNC_SAMPLES, 1'b1, 1'b0, 1'b0);
        hs0 = hs_cnt;
        vs0 = vs_cnt;
        pline("p60", 60, LINE_PERIOD - 60, 1'b0, 1'b0, 1'b0);
        check("p60 hs strobes", 32'(hs_cnt - hs0), 0);
        check("p60 vs strobes", 32'(vs_cnt - vs0), 0);
        for (int i = 1; i <= 4; i++) begin
            pline("m", HSYNC_SAMPLES, LINE_PERIOD - HSYNC_SAMPLES, 1'b1, 1'b0, i == 4);
        end

        // Missing lines: one timeout holds lock, a second in a row drops it.
        pline("t1", HSYNC_SAMPLES, LINE_PERIOD - HSYNC_SAMPLES + 400, 1'b1, 1'b0, 1'b1);
        check("t1 locked", 32'(locked), 1);
        pline("t2", HSYNC_SAMPLES, 1100, 1'b1, 1'b0, 1'b1);
        check("t2 locked", 32'(locked), 0);
        check("t2 x sat", 32'(x), 1023);

        // Reset in the middle of a pulse.
        repeat (10) step(1'b0);
        reset = 1'b1;
        repeat (2) step(1'b0);
        check("mid_rst hsync_pulse", 32'(hsync_pulse), 0);
        check("mid_rst x", 32'(x), 0);
        check("mid_rst y", 32'(y), 0);
        check("mid_rst locked", 32'(locked), 0);
        check("mid_rst active", 32'(active), 0);
        reset = 1'b0;
        hs0 = hs_cnt;
        repeat (14) step(1'b0);
        repeat (20) step(1'b1);
        check("mid_rst no hs", 32'(hs_cnt - hs0), 0);
        pline("post_rst", HSYNC_SAMPLES, 20, 1'b1, 1'b0, 1'b0);
        check("post_rst y", 32'(y), 1);

        check("hs vs overlap", 32'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/composite_sync_separator.md
# composite_sync_separator

Receive-side counterpart of the composite video generator. Recovers timing from a sliced composite signal: sync and luma comparator bits are sampled at the generator's divided rate (clk_en, 85.5 MHz / 16). The block classifies sync pulses as horizontal or vertical, measures line period to establish lock, and outputs recovered x/y counters, sync strobes, an active-video flag and the registered luma bit to downstream capture logic.

## Interface

Parameters (all counts in clk_en samples):
- HSYNC_MIN, 16: shortest low pulse accepted as hsync; shorter pulses are glitches.
- HSYNC_MAX, 40: longest low pulse accepted as hsync.
- VSYNC_MIN, 200: shortest low pulse accepted as a broad (vsync) pulse.
- LINE_SAMPLES, 341: nominal leading-edge to leading-edge line period.
- LINE_TOL, 8: allowed ± period deviation.
- LOCK_LINES, 4: consecutive good lines required to assert locked.
- ACTIVE_SAMPLES, 300: width of the active window after the sync trailing edge.
- ACTIVE_LINES, 240: active lines after vsync.

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  sample enable, one clk cycle in every 16.
- sync_n  in  1  asynchronous comparator output; 0 = composite at sync level.
- luma  in  1  asynchronous comparator output; 1 = white.
- hsync_pulse  out  1  one-clk strobe on the trailing edge of a valid hsync.
- vsync_pulse  out  1  one-clk strobe on the trailing edge of a valid broad pulse.
- x  out  10  samples since the last sync trailing edge; saturates at 1023.
- y  out  9  lines since the last vsync; saturates at 511.
- active  out  1  locked && !in_sync && x < ACTIVE_SAMPLES && y < ACTIVE_LINES.
- video  out  1  luma sampled on the same clk_en as x.
- locked  out  1  line timing locked.

## Operation

- sync_n and luma each pass through a 2-flop synchronizer. All other state advances only on clk_en cycles.
- Pulse FSM:
  - HIGH: on a sampled 0, go to LOW, clear width, evaluate period (below), clear period.
  - LOW: width increments, saturating at 511. On a sampled 1, return to HIGH and classify.
- Classification of a pulse of width w:
  - w < HSYNC_MIN: ignored, no strobe. Its leading edge has already reset the period, which is intended; a glitch then reads as a bad line.
  - HSYNC_MIN ≤ w ≤ HSYNC_MAX: hsync. Strobe hsync_pulse, x ← 0, y ← y+1 (saturating).
  - HSYNC_MAX < w < VSYNC_MIN: invalid. No strobe, and counts as a bad line.
  - w ≥ VSYNC_MIN: vsync. Strobe vsync_pulse, x ← 0, y ← 0.
- Period: a 10-bit counter increments every sample and saturates.
  - At each leading edge, the line is good iff |period − LINE_SAMPLES| ≤ LINE_TOL.
  - Timeout: when period reaches LINE_SAMPLES+LINE_TOL+1 while HIGH, the line counts as bad once per timeout.
- Lock:
  - A good line increments good_cnt, saturating at LOCK_LINES. locked ← 1 when good_cnt reaches LOCK_LINES.
  - A bad line clears good_cnt and increments bad_cnt. locked ← 0 after 2 consecutive bad lines.
  - A good line clears bad_cnt.
- x increments every sample, including during a pulse. in_sync = FSM in LOW.

## Timing

- Reset: every output is 0, FSM in HIGH, all counters 0, synchronizers cleared. A reset mid-pulse discards the pulse; the next rising edge is not classified.
- Latency: a pin edge reaches the sampled value after 2 clk plus up to 16 clk of clk_en phase. Strobes and counter updates are registered in the clk_en cycle that samples the edge and are visible on the following clk.
- Strobes are exactly one clk wide. hsync_pulse and vsync_pulse are never high together.
- x, y, video and active change only on clk after a clk_en.
- A leading edge coinciding with the timeout sample counts as a single bad line.

## Structure

- Package video_timing_pkg: the sample-count constants (HSYNC 26, broad 315, line 341, divider 16) shared with the generator, and the pulse FSM state enum.
- Sub-module sync_pulse_classifier: synchronizer, pulse FSM and width classification. Outputs pulse strobes plus leading-edge and in_sync indications.
- Top: period/lock logic and the x/y counters.

## Test plan

- Reset, then generator-timed video (26-sample hsync, 341-sample lines) → locked rises at the 4th good leading edge; hsync_pulse once per line; x = 0 the sample after each trailing edge.
- Broad pulse of 315 low + 26 black → vsync_pulse one clk, y = 0; after the next hsync y = 1.
- 5-sample low glitch mid-line while locked → no strobe. The following line reads as bad; a second glitch on the next line drops locked.
- 60-sample pulse → no strobe, good_cnt cleared; locked needs 4 further good lines.
- Sync held high for 400 samples while locked → one timeout bad line, locked held; a second missing line drops locked. x saturates at 1023.
- Assert reset during a 26-sample pulse → outputs 0; no hsync_pulse on the subsequent rising edge.
